retire_stage: RTL and testbench
===============================

// Module: retire_stage
// PURPOSE
// - Consumer end of the ROB head interface: inspects up to N oldest ROB entries each cycle.
// - Returns num_retiring to the ROB in the same cycle.
// - Frees T_old to the freelist and updates the architectural map with T_new.
// - Raises a registered pipeline flush on a retiring mispredicted branch; latches processor halt.
// - Sits between rob and freelist/arch_map; drives flush to dispatch/RS/ROB tail logic.
// PARAMETERS
// - `N (sys_defs, default 2) : superscalar width; max entries retired per cycle
// - `NUM_SCALAR_BITS (sys_defs) : width of counts 0..N
// - `PHYS_REG_ID_BITS (sys_defs) : physical register tag width
// PORTS
// - clock              in  1                    : single clock, posedge
// - reset              in  1                    : synchronous, active-high
// - rob_outputs        in  ROB_PACKET[N]        : head entries, [0] = oldest
// - rob_outputs_valid  in  NUM_SCALAR_BITS      : number of valid head entries (0..N)
// - num_retiring       out NUM_SCALAR_BITS      : entries the ROB pops at this posedge
// - free_valid         out N                    : free_reg[i] valid this cycle
// - free_reg           out PHYS_REG_ID_BITS[N]  : T_old tags returned to the freelist
// - arch_wr_en         out N                    : arch map write enable (dest != x0)
// - arch_wr_idx        out 5[N]                 : architectural register index
// - arch_wr_tag        out PHYS_REG_ID_BITS[N]  : T_new tag written
// - flush              out 1                    : registered 1-cycle squash pulse
// - flush_pc           out 32                   : redirect target, valid while flush=1
// - halted             out 1                    : sticky; a halt instruction has retired
// BEHAVIOUR
// - ROB_PACKET fields used: complete, mispredict, halt, has_dest, arch_reg, T_new, T_old, branch_target.
// - Reset outputs: num_retiring=0, free_valid=0, arch_wr_en=0, flush=0, flush_pc=0, halted=0, FSM=RUN.
// - FSM RUN (retire window, combinational):
//   - Scan i = 0..N-1; entry i is eligible iff i < rob_outputs_valid, complete=1, and all older entries are eligible.
//   - Scanning stops after (inclusive of) the first eligible entry with mispredict=1 or halt=1.
//   - num_retiring = count of eligible entries; no gaps, strictly in order.
// - Outputs for each retiring i:
//   - free_valid[i]=has_dest; free_reg[i]=T_old.
//   - arch_wr_en[i]=has_dest && arch_reg!=0; arch_wr_tag[i]=T_new.
//   - Non-retiring lanes drive all enables 0.
// - Same-cycle arch writes to the same arch_reg: the higher lane (younger) wins; lane order is documented to arch_map.
// - Transitions:
//   - Mispredict retires: next state FLUSH; flush_pc <= branch_target.
//   - Halt retires: next state HALTED.
//   - Both in one entry: halt takes priority; no flush is raised.
// - FSM FLUSH (exactly 1 cycle): flush=1, num_retiring=0, all enables 0; then back to RUN.
//   - The ROB empties on flush, so rob_outputs is ignored in this cycle.
// - FSM HALTED: halted=1, num_retiring=0, all enables 0 until reset.
// - rob_outputs_valid=0 → num_retiring=0, no side effects.
// - Incomplete oldest entry blocks all younger entries even if they are complete.
// - Reset asserted mid-FLUSH or mid-HALTED: next cycle is RUN with all outputs at their reset values.
// - num_retiring never exceeds rob_outputs_valid; zero-extend counts, no overflow possible.
// CONFIGURATION
// - RETIRE_STATS_EN defined:
//   - Adds output retired_count (64b, reset 0).
//   - Increments by num_retiring each cycle in RUN.
//   - Adds output flush_count (32b, reset 0), incremented on each entry to FLUSH.
// - Undefined: neither port nor counter exists; all other behaviour is identical.
// TESTING
// - T1: valid=1, [0].complete=1, has_dest, arch_reg=5, T_old=12, T_new=40
//   → num_retiring=1, free_reg[0]=12, arch_wr_idx[0]=5, arch_wr_tag[0]=40.
// - T2: valid=N, [0].complete=0, rest complete → num_retiring=0, no enables.
//   Set [0].complete=1 → num_retiring=N.
// - T3: valid=N, [0] complete mispredict, target=0x100
//   → num_retiring=1; next cycle flush=1, flush_pc=0x100, num_retiring=0; following cycle flush=0.
// - T4: [0] complete halt → num_retiring=1; halted=1 from next cycle.
//   Further complete entries give num_retiring=0. Reset → halted=0.
// - T5: arch_reg=0 with has_dest=1 → free_valid=1, arch_wr_en=0.
//   Same arch_reg in lanes 0 and 1 → both enables high, lane 1 tag is final.
// - T6: random complete/valid patterns for 10k cycles vs reference model of in-order prefix retirement.
//   With RETIRE_STATS_EN, retired_count equals the summed num_retiring.

Source files
------------

// File: rtl/retire_stage.sv
// Retire stage: in-order commit of up to N ROB head entries, registered flush on a
// mispredict, sticky halt. Define RETIRE_STATS_EN to add retired/flush counters.

package retire_pkg;
    localparam int N                = 2;
    localparam int NUM_SCALAR_BITS  = $clog2(N + 1);
    localparam int PHYS_REG_ID_BITS = 6;

    typedef struct packed {
        logic                        complete;
        logic                        mispredict;
        logic                        halt;
        logic                        has_dest;
        logic [4:0]                  arch_reg;
        logic [PHYS_REG_ID_BITS-1:0] T_new;
        logic [PHYS_REG_ID_BITS-1:0] T_old;
        logic [31:0]                 branch_target;
    } ROB_PACKET;
endpackage

module retire_stage
    import retire_pkg::*;
(
    input  logic                        clock,
    input  logic                        reset,
    input  ROB_PACKET                   rob_outputs [N],
    input  logic [NUM_SCALAR_BITS-1:0]  rob_outputs_valid,
    output logic [NUM_SCALAR_BITS-1:0]  num_retiring,
    output logic [N-1:0]                free_valid,
    output logic [PHYS_REG_ID_BITS-1:0] free_reg [N],
    output logic [N-1:0]                arch_wr_en,
    output logic [4:0]                  arch_wr_idx [N],
    output logic [PHYS_REG_ID_BITS-1:0] arch_wr_tag [N],
    output logic                        flush,
    output logic [31:0]                 flush_pc,
    output logic                        halted
`ifdef RETIRE_STATS_EN
    ,
    output logic [63:0]                 retired_count,
    output logic [31:0]                 flush_count
`endif
);

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        FLUSH  = 2'd1,
        HALTED = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_nextState;
    logic [31:0] r_flushPc;
    logic [N-1:0] w_retire;
    logic        w_stop;
    logic        w_takeFlush;
    logic [31:0] w_flushTarget;

    // Retire window: the in-order prefix of complete entries, closed by a mispredict or halt.
    always_comb begin
        w_retire      = '0;
        w_stop        = 1'b0;
        num_retiring  = '0;
        w_nextState   = r_state;
        w_takeFlush   = 1'b0;
        w_flushTarget = r_flushPc;
        case (r_state)
            RUN: begin
                for (int i = 0; i < N; i++) begin
                    if (!w_stop && !reset && (i < int'(rob_outputs_valid)) && rob_outputs[i].complete) begin
                        w_retire[i]  = 1'b1;
                        num_retiring = num_retiring + NUM_SCALAR_BITS'(1);
                        if (rob_outputs[i].halt) begin
                            w_nextState = HALTED;
                            w_stop      = 1'b1;
                        end else if (rob_outputs[i].mispredict) begin
                            w_nextState   = FLUSH;
                            w_takeFlush   = 1'b1;
                            w_flushTarget = rob_outputs[i].branch_target;
                            w_stop        = 1'b1;
                        end
                    end else begin
                        w_stop = 1'b1;
                    end
                end
            end
            FLUSH:   w_nextState = RUN;
            default: w_nextState = r_state;
        endcase
    end

    always_comb begin
        free_valid = '0;
        arch_wr_en = '0;
        for (int i = 0; i < N; i++) begin
            free_valid[i]  = w_retire[i] && rob_outputs[i].has_dest;
            free_reg[i]    = rob_outputs[i].T_old;
            arch_wr_en[i]  = w_retire[i] && rob_outputs[i].has_dest && (rob_outputs[i].arch_reg != 5'd0);
            arch_wr_idx[i] = rob_outputs[i].arch_reg;
            arch_wr_tag[i] = rob_outputs[i].T_new;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state   <= RUN;
            r_flushPc <= '0;
        end else begin
            r_state <= w_nextState;
            if (w_takeFlush) begin
                r_flushPc <= w_flushTarget;
            end
        end
    end

    assign flush    = (r_state == FLUSH);
    assign halted   = (r_state == HALTED);
    assign flush_pc = r_flushPc;

`ifdef RETIRE_STATS_EN
    logic [63:0] r_retiredCount;
    logic [31:0] r_flushCount;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_retiredCount <= '0;
            r_flushCount   <= '0;
        end else begin
            r_retiredCount <= r_retiredCount + 64'(num_retiring);
            if (w_takeFlush) begin
                r_flushCount <= r_flushCount + 32'd1;
            end
        end
    end

    assign retired_count = r_retiredCount;
    assign flush_count   = r_flushCount;
`endif

endmodule

// File: tb/tb_retire_stage.sv
// Scoreboard bench for retire_stage: stimulus pushes model expectations into a queue,
// a negedge monitor pops and compares them against the DUT outputs.

module tb_retire_stage;
    import retire_pkg::*;

    localparam int P = PHYS_REG_ID_BITS;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic                       reset;
    ROB_PACKET                  robOutputs [N];
    logic [NUM_SCALAR_BITS-1:0] robValid;
    logic [NUM_SCALAR_BITS-1:0] numRetiring;
    logic [N-1:0]               freeValid;
    logic [P-1:0]               freeReg [N];
    logic [N-1:0]               archWrEn;
    logic [4:0]                 archWrIdx [N];
    logic [P-1:0]               archWrTag [N];
    logic                       flush;
    logic [31:0]                flushPc;
    logic                       halted;
`ifdef RETIRE_STATS_EN
    logic [63:0]                retiredCount;
    logic [31:0]                flushCount;
`endif

    retire_stage dut (
        .clock             (clock),
        .reset             (reset),
        .rob_outputs       (robOutputs),
        .rob_outputs_valid (robValid),
        .num_retiring      (numRetiring),
        .free_valid        (freeValid),
        .free_reg          (freeReg),
        .arch_wr_en        (archWrEn),
        .arch_wr_idx       (archWrIdx),
        .arch_wr_tag       (archWrTag),
        .flush             (flush),
        .flush_pc          (flushPc),
        .halted            (halted)
`ifdef RETIRE_STATS_EN
        ,
        .retired_count     (retiredCount),
        .flush_count       (flushCount)
`endif
    );

    typedef struct packed {
        logic [NUM_SCALAR_BITS-1:0] numRet;
        logic [N-1:0]               fv;
        logic [N-1:0][P-1:0]        fr;
        logic [N-1:0]               we;
        logic [N-1:0][4:0]          wi;
        logic [N-1:0][P-1:0]        wt;
        logic                       flush;
        logic [31:0]                fpc;
        logic                       halted;
        logic [31:0][P-1:0]         archMap;
        logic [63:0]                retired;
        logic [31:0]                flushes;
    } expect_t;

    expect_t expQ [$];

    // Reference model: machine mode (0 run, 1 flushing, 2 halted) plus the architectural map
    // as it looks after committing instructions one at a time in program order.
    int                 mState    = 0;
    logic [31:0]        mFlushPc  = '0;
    logic [63:0]        mRetired  = '0;
    logic [31:0]        mFlushes  = '0;
    logic [31:0][P-1:0] modelArch = '0;
    logic [31:0][P-1:0] dutArch   = '0;
    ROB_PACKET          stim [N];

    int total = 0;
    int bad   = 0;

    function automatic ROB_PACKET mk(input bit c, input bit mp, input bit h, input bit hd,
                                     input int ar, input int tn, input int to, input int tgt);
        ROB_PACKET p;
        p.complete      = c;
        p.mispredict    = mp;
        p.halt          = h;
        p.has_dest      = hd;
        p.arch_reg      = ar[4:0];
        p.T_new         = tn[P-1:0];
        p.T_old         = to[P-1:0];
        p.branch_target = tgt;
        return p;
    endfunction

    task automatic clearStim();
        for (int i = 0; i < N; i++) stim[i] = '0;
    endtask

    // Drive one cycle of inputs and queue what the retire stage must show for it.
    task automatic applyStimulus(input int valid, input bit doReset);
        expect_t e;
        int k;
        @(posedge clock);
        #1;
        robOutputs = stim;
        robValid   = NUM_SCALAR_BITS'(valid);
        reset      = doReset;
        e          = '0;
        e.flush    = (mState == 1);
        e.halted   = (mState == 2);
        e.fpc      = mFlushPc;
        e.retired  = mRetired;
        e.flushes  = mFlushes;
        k = 0;
        if (!doReset && mState == 0) begin
            for (int i = 0; i < valid; i++) begin
                if (!stim[i].complete) break;
                k++;
                if (stim[i].mispredict || stim[i].halt) break;
            end
        end
        e.numRet = NUM_SCALAR_BITS'(k);
        for (int i = 0; i < k; i++) begin
            e.fv[i] = stim[i].has_dest;
            e.fr[i] = stim[i].T_old;
            e.we[i] = stim[i].has_dest && (stim[i].arch_reg != 0);
            e.wi[i] = stim[i].arch_reg;
            e.wt[i] = stim[i].T_new;
            if (e.we[i]) modelArch[stim[i].arch_reg] = stim[i].T_new;
        end
        e.archMap = modelArch;
        expQ.push_back(e);
        if (doReset) begin
            mState   = 0;
            mFlushPc = '0;
            mRetired = '0;
            mFlushes = '0;
        end else if (mState == 1) begin
            mState = 0;
        end else if (mState == 0 && k > 0) begin
            mRetired = mRetired + 64'(k);
            if (stim[k-1].halt) begin
                mState = 2;
            end else if (stim[k-1].mispredict) begin
                mState   = 1;
                mFlushPc = stim[k-1].branch_target;
                mFlushes = mFlushes + 1;
            end
        end
    endtask

    task automatic compareValue(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic checkOutput(input expect_t e);
        compareValue("num_retiring", 64'(numRetiring), 64'(e.numRet));
        compareValue("free_valid", 64'(freeValid), 64'(e.fv));
        compareValue("arch_wr_en", 64'(archWrEn), 64'(e.we));
        for (int i = 0; i < N; i++) begin
            if (e.fv[i]) compareValue($sformatf("free_reg[%0d]", i), 64'(freeReg[i]), 64'(e.fr[i]));
            if (e.we[i]) begin
                compareValue($sformatf("arch_wr_idx[%0d]", i), 64'(archWrIdx[i]), 64'(e.wi[i]));
                compareValue($sformatf("arch_wr_tag[%0d]", i), 64'(archWrTag[i]), 64'(e.wt[i]));
            end
        end
        compareValue("flush", 64'(flush), 64'(e.flush));
        compareValue("flush_pc", 64'(flushPc), 64'(e.fpc));
        compareValue("halted", 64'(halted), 64'(e.halted));
        for (int i = 0; i < N; i++) begin
            if (archWrEn[i] === 1'b1) dutArch[archWrIdx[i]] = archWrTag[i];
        end
        total++;
        if (dutArch !== e.archMap) begin
            bad++;
            $display("[TB] FAIL arch_map actual=%0h expected=%0h at %0t", dutArch, e.archMap, $time);
        end
`ifdef RETIRE_STATS_EN
        compareValue("retired_count", retiredCount, e.retired);
        compareValue("flush_count", 64'(flushCount), 64'(e.flushes));
`endif
    endtask

    initial begin
        forever begin
            @(negedge clock);
            if (expQ.size() > 0) checkOutput(expQ.pop_front());
        end
    end

    initial begin
        reset    = 1'b1;
        robValid = '0;
        clearStim();
        robOutputs = stim;

        applyStimulus(0, 1);
        $display("[TB] single retire");
        stim[0] = mk(1, 0, 0, 1, 5, 40, 12, 0);
        applyStimulus(1, 0);

        $display("[TB] incomplete head blocks younger entries");
        stim[0] = mk(0, 0, 0, 1, 3, 10, 11, 0);
        stim[1] = mk(1, 0, 0, 1, 4, 14, 15, 0);
        applyStimulus(2, 0);
        stim[0].complete = 1'b1;
        applyStimulus(2, 0);
        applyStimulus(0, 0);

        $display("[TB] mispredict flush");
        stim[0] = mk(1, 1, 0, 1, 6, 20, 21, 32'h100);
        stim[1] = mk(1, 0, 0, 1, 7, 22, 23, 0);
        applyStimulus(2, 0);
        applyStimulus(2, 0);
        clearStim();
        applyStimulus(0, 0);

        $display("[TB] halt");
        stim[0] = mk(1, 0, 1, 0, 0, 0, 0, 0);
        stim[1] = mk(1, 0, 0, 1, 8, 24, 25, 0);
        applyStimulus(2, 0);
        stim[0] = mk(1, 0, 0, 1, 8, 26, 27, 0);
        repeat (3) applyStimulus(2, 0);
        applyStimulus(2, 1);
        applyStimulus(0, 0);

        $display("[TB] halt and mispredict in one entry");
        stim[0] = mk(1, 1, 1, 1, 10, 33, 34, 32'h200);
        applyStimulus(1, 0);
        applyStimulus(1, 0);
        applyStimulus(0, 1);

        $display("[TB] reset during flush");
        stim[0] = mk(1, 1, 0, 0, 0, 0, 0, 32'h300);
        applyStimulus(1, 0);
        applyStimulus(1, 1);
        clearStim();
        applyStimulus(0, 0);

        $display("[TB] x0 destination and same-register lanes");
        stim[0] = mk(1, 0, 0, 1, 0, 30, 31, 0);
        applyStimulus(1, 0);
        stim[0] = mk(1, 0, 0, 1, 9, 20, 2, 0);
        stim[1] = mk(1, 0, 0, 1, 9, 21, 3, 0);
        applyStimulus(2, 0);

        $display("[TB] random traffic");
        for (int c = 0; c < 10000; c++) begin
            for (int i = 0; i < N; i++) begin
                stim[i] = mk(($urandom % 4) != 0, ($urandom % 12) == 0, ($urandom % 150) == 0,
                             ($urandom % 4) != 0, $urandom_range(0, 31), $urandom, $urandom, $urandom);
            end
            applyStimulus($urandom_range(0, N), ($urandom % 200) == 0);
        end
        clearStim();
        applyStimulus(0, 0);

        repeat (5) @(negedge clock);
        total++;
        if (expQ.size() != 0) begin
            bad++;
            $display("[TB] FAIL queue_drain actual=%0d expected=0", expQ.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
